motor_bridge_driver: RTL and testbench
======================================

// Module: motor_bridge_driver
// PURPOSE
//  Back end of the motor command interface: takes the 4-bit direction word and 2-bit enable
//  from the line-following Motor controller and drives the dual H-bridge (IN1..IN4, ENA/ENB).
//  Adds per-channel PWM speed control and dead-time insertion on every direction reversal,
//  so the bridge never sees an instant forward<->backward swap.
// PARAMETERS
//  PWM_BITS     8    width of free-running PWM counter and duty inputs
//  DEAD_CYCLES  16   clocks both bridge inputs held 00 / enable low on a reversal (>=1)
//  RAMP_DIV     4    PWM periods per +1 duty step (used only with MOTOR_SOFT_START_EN)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         asynchronous reset, active high
//  motorIn    in   4         [3:2] left pair, [1:0] right pair; 01/10 = the two directions
//  motorEn    in   2         [1] left enable, [0] right enable
//  duty_l     in   PWM_BITS  left duty (0 = off)
//  duty_r     in   PWM_BITS  right duty
//  hb_in      out  4         bridge direction pins, same bit mapping as motorIn
//  hb_en      out  2         bridge enable (PWM), [1] left, [0] right
//  dead_busy  out  2         channel currently in dead time
// BEHAVIOUR
//  - rst high: all outputs 0 immediately; channels IDLE; PWM and dead counters 0.
//  - Inputs registered every edge into cmd_q; FSMs act on cmd_q; all outputs registered.
//    Latency input->output: 2 clocks.
//  - Channel pair code 00 or 11 = STOP (treated same as enable low); never driven to bridge.
//  - Per-channel FSM, channels independent:
//    IDLE: hb pair 00, en 0. Legal code & enable -> RUN with that direction (no dead time).
//    RUN : hb pair = latched dir, en = PWM. Enable low or STOP -> IDLE.
//          Code equals latched dir -> stay. Opposite code -> DEAD, counter = DEAD_CYCLES-1.
//    DEAD: hb pair 00, en 0, dead_busy 1. Enable low or STOP -> IDLE at once.
//          Counter decrements; at 0 -> RUN with the direction in cmd_q that cycle
//          (command changes during DEAD do not restart the counter).
//  - DEAD lasts exactly DEAD_CYCLES clocks of hb pair 00 between the two directions.
//  - PWM: one shared PWM_BITS counter, free-running, wraps 2^PWM_BITS-1 -> 0.
//    hb_en[i] = (state==RUN) && (pwm_cnt < duty_eff_i); duty 0 -> never high,
//    duty all-ones -> high (2^N-1)/2^N of period. Duty inputs sampled with cmd_q.
//  - Both channels reversing on the same edge: each runs its own DEAD independently.
//  - IDLE->RUN with reversed direction is allowed without dead time (stop must be
//    held by upstream logic if required).
// CONFIGURATION
//  MOTOR_SOFT_START_EN defined:
//    duty_eff_i reset to 0 on every entry to RUN; +1 every RAMP_DIV PWM wraps,
//    saturating at duty_x; if duty_x drops below duty_eff, duty_eff = duty_x next clock.
//  MOTOR_SOFT_START_EN undefined:
//    duty_eff_i = registered duty_x; RAMP_DIV unused; no ramp logic synthesised.
// TESTING  (PWM_BITS=8, DEAD_CYCLES=16, soft start off unless stated)
//  1 rst mid-RUN -> hb_in=0000, hb_en=00, dead_busy=00 same cycle; stays IDLE after release.
//  2 motorIn=0110, motorEn=11, duty=128 -> 2 clk later hb_in=0110; hb_en high 128 of 256 clk.
//  3 RUN 0110 then motorIn=1010 -> left pair 00 for exactly 16 clk, dead_busy[1]=1,
//    then hb_in=1010; right pair unchanged 10, no gap.
//  4 During DEAD drop motorEn[1] -> left IDLE next clk, dead_busy[1]=0, no RUN resumes.
//  5 motorIn=1111 or 0000 with motorEn=11 -> hb_in=0000, hb_en=00 permanently.
//  6 MOTOR_SOFT_START_EN, RAMP_DIV=4, duty=8 -> high time per period 0,0,0,0,1,...,
//    reaches 8/256 after 32 periods; reverse restarts ramp at 0 after dead time.

Source files
------------

// File: rtl/motor_bridge_driver.sv
// motor_bridge_driver
// Back end of the motor command path. It takes the 4-bit direction word and the
// 2-bit enable from the line-following controller and drives a dual H-bridge.
// Each channel has its own PWM duty. A dead time of DEAD_CYCLES clocks, with the
// bridge pair at 00 and the enable low, is inserted on every direction reversal.
// Optional feature: define MOTOR_SOFT_START_EN to ramp the effective duty from 0
// by one step every RAMP_DIV PWM periods after each entry into RUN.
module motor_bridge_driver #(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 16,
   parameter int RAMP_DIV    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          motorIn,
   input  logic [1:0]          motorEn,
   input  logic [PWM_BITS-1:0] duty_l,
   input  logic [PWM_BITS-1:0] duty_r,
   output logic [3:0]          hb_in,
   output logic [1:0]          hb_en,
   output logic [1:0]          dead_busy
);

   localparam int               CNT_W     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   // Command register: every input is sampled once before the channel FSMs see it
   logic [3:0]          cmd_in_q, cmd_in_d;
   logic [1:0]          cmd_en_q, cmd_en_d;
   logic [PWM_BITS-1:0] duty_l_q, duty_l_d;
   logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

   // Next values for the command register and the free-running PWM counter
   always_comb begin
      cmd_in_d  = motorIn;
      cmd_en_d  = motorEn;
      duty_l_d  = duty_l;
      duty_r_d  = duty_r;
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
   end

   // Command and PWM counter flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_in_q  <= '0;
         cmd_en_q  <= '0;
         duty_l_q  <= '0;
         duty_r_q  <= '0;
         pwm_cnt_q <= '0;
      end else begin
         cmd_in_q  <= cmd_in_d;
         cmd_en_q  <= cmd_en_d;
         duty_l_q  <= duty_l_d;
         duty_r_q  <= duty_r_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   // Per-channel registered outputs, gathered into the packed ports below.
   // Index 1 is the left channel, index 0 the right channel.
   logic [1:0] pair_o [2];
   logic       en_o   [2];
   logic       busy_o [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0]          code;
      logic                en_cmd;
      logic                legal;
      logic [PWM_BITS-1:0] duty;
      logic [PWM_BITS-1:0] duty_eff;

      state_t              state_q, state_d;
      logic [1:0]          dir_q, dir_d;
      logic [CNT_W-1:0]    cnt_q, cnt_d;
      logic [1:0]          pair_q, pair_d;
      logic                en_q, en_d;
      logic                busy_q, busy_d;

      assign code   = cmd_in_q[2*gi +: 2];
      assign en_cmd = cmd_en_q[gi];
      assign duty   = (gi == 1) ? duty_l_q : duty_r_q;
      // 00 and 11 are STOP codes and behave exactly like a low enable
      assign legal  = en_cmd && ((code == 2'b01) || (code == 2'b10));

      // Channel FSM: IDLE / RUN / DEAD transitions and the dead-time counter
      always_comb begin
         state_d = state_q;
         dir_d   = dir_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_IDLE: begin
               if (legal) begin
                  state_d = ST_RUN;
                  dir_d   = code;
               end
            end
            ST_RUN: begin
               if (!legal) begin
                  state_d = ST_IDLE;
               end else if (code != dir_q) begin
                  state_d = ST_DEAD;
                  cnt_d   = DEAD_LOAD;
               end
            end
            ST_DEAD: begin
               if (!legal) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  // Resume with whatever legal direction is commanded now
                  state_d = ST_RUN;
                  dir_d   = code;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef MOTOR_SOFT_START_EN
      localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

      logic [PWM_BITS-1:0] duty_eff_q, duty_eff_d;
      logic [RAMP_W-1:0]   ramp_q, ramp_d;
      logic                run_entry;
      logic                ramp_tick;

      assign run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
      assign ramp_tick = (pwm_cnt_q == '1) && (ramp_q == RAMP_W'(RAMP_DIV - 1));

      // Soft-start ramp: restart at 0 on entering RUN, step every RAMP_DIV wraps
      always_comb begin
         duty_eff_d = duty_eff_q;
         ramp_d     = ramp_q;
         if (run_entry) begin
            duty_eff_d = '0;
            ramp_d     = '0;
         end else if (state_q == ST_RUN) begin
            if (pwm_cnt_q == '1) begin
               ramp_d = ramp_tick ? '0 : ramp_q + RAMP_W'(1);
            end
            if (duty < duty_eff_q) begin
               duty_eff_d = duty;
            end else if (ramp_tick && (duty_eff_q < duty)) begin
               duty_eff_d = duty_eff_q + PWM_BITS'(1);
            end
         end
      end

      // Soft-start ramp flops
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            duty_eff_q <= '0;
            ramp_q     <= '0;
         end else begin
            duty_eff_q <= duty_eff_d;
            ramp_q     <= ramp_d;
         end
      end

      assign duty_eff = duty_eff_d;
`else
      // Without soft start the sampled duty is used directly
      assign duty_eff = duty;
      if (RAMP_DIV < 1) begin : g_ramp_div_unused
      end
`endif

      // Output decode from the next state so the pins line up with the state flops
      always_comb begin
         pair_d = (state_d == ST_RUN) ? dir_d : 2'b00;
         en_d   = (state_d == ST_RUN) && (pwm_cnt_q < duty_eff);
         busy_d = (state_d == ST_DEAD);
      end

      // Channel state and output flops
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 2'b00;
            cnt_q   <= '0;
            pair_q  <= 2'b00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
         end
      end

      assign pair_o[gi] = pair_q;
      assign en_o[gi]   = en_q;
      assign busy_o[gi] = busy_q;
   end

   assign hb_in     = {pair_o[1], pair_o[0]};
   assign hb_en     = {en_o[1], en_o[0]};
   assign dead_busy = {busy_o[1], busy_o[0]};

endmodule

// File: tb/tb_motor_bridge_driver.sv
// tb_motor_bridge_driver
// Table-driven vectors, hand-written reversal / abort / reset sequences and a
// randomized phase checked against a cycle-level behavioural model of the
// bridge driver (default build, soft start disabled).
module tb_motor_bridge_driver;

   localparam int PWM_BITS    = 8;
   localparam int DEAD_CYCLES = 16;
   localparam int PERIOD      = 256;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [3:0]          motorIn = 4'b0000;
   logic [1:0]          motorEn = 2'b00;
   logic [PWM_BITS-1:0] duty_l = '0;
   logic [PWM_BITS-1:0] duty_r = '0;
   logic [3:0]          hb_in;
   logic [1:0]          hb_en;
   logic [1:0]          dead_busy;

   motor_bridge_driver #(
      .PWM_BITS    (PWM_BITS),
      .DEAD_CYCLES (DEAD_CYCLES),
      .RAMP_DIV    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .motorIn   (motorIn),
      .motorEn   (motorEn),
      .duty_l    (duty_l),
      .duty_r    (duty_r),
      .hb_in     (hb_in),
      .hb_en     (hb_en),
      .dead_busy (dead_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 stopped, 1 driving, 2 waiting out the dead time.
   // m_zeros counts dead-time clocks already shown on the bridge.
   int         m_mode  [2];
   int         m_dir   [2];
   int         m_zeros [2];
   int         m_duty  [2];
   logic [3:0] m_in;
   logic [1:0] m_en;
   int         m_pwm;
   logic [3:0] e_hb;
   logic [1:0] e_en;
   logic [1:0] e_busy;
   bit         cmp_en = 1'b0;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_mode[c]  = 0;
         m_dir[c]   = 0;
         m_zeros[c] = 0;
         m_duty[c]  = 0;
      end
      m_in   = 4'b0000;
      m_en   = 2'b00;
      m_pwm  = 0;
      e_hb   = 4'b0000;
      e_en   = 2'b00;
      e_busy = 2'b00;
   endtask

   // One clock: advance the model on the edge, then sample the DUT 1 ns later
   task automatic tick();
      int  code;
      bit  legal;
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         code  = int'(m_in[2*c +: 2]);
         legal = m_en[c] && (code == 1 || code == 2);
         if (!legal) begin
            m_mode[c] = 0;
         end else if (m_mode[c] == 0) begin
            m_mode[c] = 1;
            m_dir[c]  = code;
         end else if (m_mode[c] == 1) begin
            if (code != m_dir[c]) begin
               m_mode[c]  = 2;
               m_zeros[c] = 1;
            end
         end else begin
            if (m_zeros[c] >= DEAD_CYCLES) begin
               m_mode[c] = 1;
               m_dir[c]  = code;
            end else begin
               m_zeros[c]++;
            end
         end
         e_hb[2*c +: 2] = (m_mode[c] == 1) ? 2'(m_dir[c]) : 2'b00;
         e_en[c]        = (m_mode[c] == 1) && (m_pwm < m_duty[c]);
         e_busy[c]      = (m_mode[c] == 2);
      end
      m_pwm     = (m_pwm + 1) % PERIOD;
      m_in      = motorIn;
      m_en      = motorEn;
      m_duty[1] = int'(duty_l);
      m_duty[0] = int'(duty_r);
      #1;
      if (cmp_en) begin
         check("rand hb_in", int'(hb_in), int'(e_hb));
         check("rand hb_en", int'(hb_en), int'(e_en));
         check("rand dead_busy", int'(dead_busy), int'(e_busy));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] m_in;
      logic [1:0] m_en;
      logic [7:0] dl;
      logic [7:0] dr;
      int         hold;
      logic [3:0] exp_hb;
      logic [1:0] exp_busy;
      int         exp_cl;   // expected left high clocks per 256, -1 = skip
      int         exp_cr;
   } vec_t;

   vec_t vecs [8];

   int cl, cr, zc, bc, rbad, first0, lbad, ibad;
   int r, pc, hold;
   logic [3:0] mi;
   logic [1:0] me;

   initial begin
      vecs[0] = '{4'b0110, 2'b11, 8'd128, 8'd128, 3,  4'b0110, 2'b00, 128, 128};
      vecs[1] = '{4'b0110, 2'b11, 8'd0,   8'd255, 3,  4'b0110, 2'b00, 0,   255};
      vecs[2] = '{4'b1111, 2'b11, 8'd100, 8'd100, 3,  4'b0000, 2'b00, 0,   0};
      vecs[3] = '{4'b0000, 2'b11, 8'd100, 8'd100, 3,  4'b0000, 2'b00, 0,   0};
      vecs[4] = '{4'b1001, 2'b10, 8'd50,  8'd50,  3,  4'b1000, 2'b00, 50,  0};
      vecs[5] = '{4'b0101, 2'b01, 8'd50,  8'd50,  3,  4'b0001, 2'b00, 0,   50};
      vecs[6] = '{4'b1010, 2'b11, 8'd200, 8'd1,   3,  4'b1000, 2'b01, -1,  -1};
      vecs[7] = '{4'b1010, 2'b11, 8'd200, 8'd1,   20, 4'b1010, 2'b00, 200, 1};

      // Reset state
      model_reset();
      #12;
      check("reset hb_in", int'(hb_in), 0);
      check("reset hb_en", int'(hb_en), 0);
      check("reset dead_busy", int'(dead_busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table vectors (state carries from one entry to the next)
      for (int i = 0; i < 8; i++) begin
         motorIn = vecs[i].m_in;
         motorEn = vecs[i].m_en;
         duty_l  = vecs[i].dl;
         duty_r  = vecs[i].dr;
         repeat (vecs[i].hold) tick();
         $display("vec %0d: motorIn=%b motorEn=%b duty=%0d/%0d -> hb_in=%b dead_busy=%b",
                  i, vecs[i].m_in, vecs[i].m_en, vecs[i].dl, vecs[i].dr, hb_in, dead_busy);
         check($sformatf("vec%0d hb_in", i), int'(hb_in), int'(vecs[i].exp_hb));
         check($sformatf("vec%0d dead_busy", i), int'(dead_busy), int'(vecs[i].exp_busy));
         if (vecs[i].exp_cl >= 0) begin
            cl = 0;
            cr = 0;
            repeat (PERIOD) begin
               tick();
               cl += int'(hb_en[1]);
               cr += int'(hb_en[0]);
            end
            check($sformatf("vec%0d left high count", i), cl, vecs[i].exp_cl);
            check($sformatf("vec%0d right high count", i), cr, vecs[i].exp_cr);
         end
      end

      // Reversal: left pair 00 for exactly DEAD_CYCLES clocks, right undisturbed
      motorIn = 4'b0110;
      motorEn = 2'b11;
      duty_l  = 8'd255;
      duty_r  = 8'd255;
      repeat (25) tick();
      check("rev setup hb_in", int'(hb_in), 6);
      motorIn = 4'b1010;
      zc = 0; bc = 0; rbad = 0; first0 = -1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (hb_in[3:2] == 2'b00) begin
            zc++;
            if (first0 < 0) first0 = k;
         end
         if (dead_busy[1]) bc++;
         if (hb_in[1:0] != 2'b10) rbad++;
      end
      $display("reversal: zero clocks=%0d busy clocks=%0d first zero=%0d", zc, bc, first0);
      check("rev dead length", zc, DEAD_CYCLES);
      check("rev busy length", bc, DEAD_CYCLES);
      check("rev latency", first0, 2);
      check("rev right disturbed", rbad, 0);
      check("rev final hb_in", int'(hb_in), 10);

      // Enable dropped during dead time: channel stops, never resumes
      motorIn = 4'b0110;
      repeat (5) tick();
      check("abort busy before drop", int'(dead_busy[1]), 1);
      motorEn = 2'b01;
      tick();
      tick();
      check("abort busy after drop", int'(dead_busy[1]), 0);
      check("abort left pair", int'(hb_in[3:2]), 0);
      lbad = 0;
      repeat (30) begin
         tick();
         if (hb_in[3:2] != 2'b00 || hb_en[1] || dead_busy[1]) lbad++;
      end
      $display("abort: left active clocks after drop=%0d", lbad);
      check("abort left stays idle", lbad, 0);

      // Asynchronous reset while running
      motorIn = 4'b0110;
      motorEn = 2'b11;
      repeat (5) tick();
      check("rst setup hb_in", int'(hb_in), 6);
      #2 rst = 1'b1;
      #1;
      check("async rst hb_in", int'(hb_in), 0);
      check("async rst hb_en", int'(hb_en), 0);
      check("async rst dead_busy", int'(dead_busy), 0);
      motorIn = 4'b0000;
      motorEn = 2'b00;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      ibad = 0;
      repeat (5) begin
         tick();
         if (hb_in != 4'b0000 || hb_en != 2'b00 || dead_busy != 2'b00) ibad++;
      end
      $display("reset: active clocks after release=%0d", ibad);
      check("rst stays idle", ibad, 0);

      // Randomized segments against the model
      cmp_en = 1'b1;
      for (int s = 0; s < 80; s++) begin
         for (int c = 0; c < 2; c++) begin
            r  = $urandom_range(0, 9);
            pc = (r < 4) ? 1 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
            mi[2*c +: 2] = 2'(pc);
            me[c]        = ($urandom_range(0, 99) < 85);
         end
         motorIn = mi;
         motorEn = me;
         r = $urandom_range(0, 9);
         duty_l = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         duty_r = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 255));
         hold = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(4, 40);
         $display("rand %0d: motorIn=%b motorEn=%b duty=%0d/%0d hold=%0d",
                  s, motorIn, motorEn, duty_l, duty_r, hold);
         repeat (hold) tick();
      end
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
